// File: rtl/edge_conditioner.sv
// Per-channel synchroniser, debouncer and edge detector for board inputs.
// Produces debounced level plus one-cycle rise/fall/mode-filtered pulses.
module edge_conditioner #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_COUNT    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CH-1:0]   in,
  input  logic [2*CH-1:0] mode,
  output logic [CH-1:0]   level,
  output logic [CH-1:0]   rise,
  output logic [CH-1:0]   fall,
  output logic [CH-1:0]   pulse,
  output logic            any_pulse
);

  localparam int CW = $clog2(DB_COUNT + 1);
  localparam logic [CW-1:0] CMAX = CW'(DB_COUNT - 1);

  logic [CH-1:0] lvl_d;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   lvl;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync <= '0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], in[i]};
      end
    end

    // level only moves after DB_COUNT consecutive disagreeing cycles
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (s == lvl) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        lvl <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign level[i] = lvl;
    assign pulse[i] = (mode[2*i]   & rise[i])
                    | (mode[2*i+1] & fall[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_d <= '0;
    end else begin
      lvl_d <= level;
    end
  end

  assign rise      = level & ~lvl_d;
  assign fall      = ~level & lvl_d;
  assign any_pulse = |pulse;

endmodule

// File: tb/tb_edge_conditioner.sv
// Bench for edge_conditioner: directed scenarios plus randomized traffic
// checked every cycle against a sliding-window reference model.
module tb_edge_conditioner;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int DB = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH-1:0]   in;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   level;
  logic [CH-1:0]   rise;
  logic [CH-1:0]   fall;
  logic [CH-1:0]   pulse;
  logic            any_pulse;

  edge_conditioner #(
    .CH(CH),
    .SYNC_STAGES(SS),
    .DB_COUNT(DB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in(in),
    .mode(mode),
    .level(level),
    .rise(rise),
    .fall(fall),
    .pulse(pulse),
    .any_pulse(any_pulse)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // reference state: raw input history, debounced level and its delay
  logic [CH-1:0] hist[$];
  logic [CH-1:0] lvl_m;
  logic [CH-1:0] lvld_m;

  // observation counters for directed scenarios
  int            rise_cnt[CH];
  int            fall_cnt[CH];
  int            pulse_cnt[CH];
  int            any_cnt;
  logic [CH-1:0] first_rise;
  int            cyc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // raw sample taken k edges before the newest one; 0 before history
  function automatic logic [CH-1:0] past(input int k);
    int idx;
    idx = hist.size() - 1 - k;
    if (idx < 0) return '0;
    return hist[idx];
  endfunction

  // a channel's level takes the synchronised value once the last DB
  // synchronised samples all agree and differ from the current level
  task automatic model_edge();
    logic [CH-1:0] nl;
    logic [CH-1:0] w;
    logic          v;
    logic          stable;
    nl = lvl_m;
    hist.push_back(in);
    if (hist.size() > SS + DB + 4) void'(hist.pop_front());
    for (int c = 0; c < CH; c++) begin
      w = past(SS);
      v = w[c];
      stable = 1'b1;
      for (int j = 1; j < DB; j++) begin
        w = past(SS + j);
        if (w[c] != v) stable = 1'b0;
      end
      if (stable && v != lvl_m[c]) nl[c] = v;
    end
    lvld_m = lvl_m;
    lvl_m  = nl;
  endtask

  task automatic check_out();
    logic [CH-1:0] r, f, p;
    r = lvl_m & ~lvld_m;
    f = ~lvl_m & lvld_m;
    for (int c = 0; c < CH; c++)
      p[c] = (mode[2*c] & r[c]) | (mode[2*c+1] & f[c]);
    chk("level", 32'(level), 32'(lvl_m));
    chk("rise", 32'(rise), 32'(r));
    chk("fall", 32'(fall), 32'(f));
    chk("pulse", 32'(pulse), 32'(p));
    chk("any_pulse", 32'(any_pulse), 32'(|p));
  endtask

  task automatic clear_cnt();
    for (int c = 0; c < CH; c++) begin
      rise_cnt[c]  = 0;
      fall_cnt[c]  = 0;
      pulse_cnt[c] = 0;
    end
    any_cnt    = 0;
    first_rise = '0;
    cyc        = 0;
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    check_out();
    cyc++;
    for (int c = 0; c < CH; c++) begin
      rise_cnt[c]  += int'(rise[c]);
      fall_cnt[c]  += int'(fall[c]);
      pulse_cnt[c] += int'(pulse[c]);
    end
    any_cnt += int'(any_pulse);
    if (first_rise == '0 && rise != '0) first_rise = rise;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    hist.delete();
    lvl_m  = '0;
    lvld_m = '0;
    check_out();
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int lat;
  int exp_p[4] = '{0, 1, 1, 2};
  int hold[CH];

  initial begin
    in   = '0;
    mode = '0;
    clear_cnt();
    apply_reset();
    settle(3);
    reset = 1'b0;
    settle(3);

    // clean press on channel 0
    mode = 8'h55;
    clear_cnt();
    lat = -1;
    in[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (level[0] && lat < 0) lat = k;
    end
    chk("press_lat", 32'(lat), 32'd6);
    chk("press_rise", 32'(rise_cnt[0]), 32'd1);
    chk("press_pulse", 32'(pulse_cnt[0]), 32'd1);
    chk("press_fall", 32'(fall_cnt[0]), 32'd0);
    chk("press_any", 32'(any_cnt), 32'd1);

    // bounce on channel 1, then a steady hold
    clear_cnt();
    for (int k = 0; k < 20; k++) begin
      in[1] = (k % 2 == 0);
      step();
    end
    chk("bounce_rise", 32'(rise_cnt[1]), 32'd0);
    chk("bounce_lvl", 32'(level[1]), 32'd0);
    clear_cnt();
    lat = -1;
    in[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (rise[1] && lat < 0) lat = k;
    end
    chk("bounce_lat", 32'(lat), 32'd6);
    chk("bounce_once", 32'(rise_cnt[1]), 32'd1);

    // mode filtering on channel 2
    for (int m = 0; m < 4; m++) begin
      mode[5:4] = 2'(m);
      clear_cnt();
      in[2] = 1'b1;
      settle(10);
      in[2] = 1'b0;
      settle(10);
      chk($sformatf("mode%0d_pulse", m), 32'(pulse_cnt[2]),
          32'(exp_p[m]));
      chk($sformatf("mode%0d_rise", m), 32'(rise_cnt[2]), 32'd1);
      chk($sformatf("mode%0d_fall", m), 32'(fall_cnt[2]), 32'd1);
    end

    // simultaneous channels
    in = '0;
    settle(10);
    mode = 8'hFF;
    clear_cnt();
    in = 4'hF;
    settle(10);
    chk("simul_rise", 32'(first_rise), 32'hF);
    chk("simul_any", 32'(any_cnt), 32'd1);

    // reset asserted mid-count on channel 3
    in = '0;
    settle(10);
    clear_cnt();
    in[3] = 1'b1;
    settle(3);
    apply_reset();
    settle(3);
    chk("rstmid_pulse", 32'(pulse_cnt[3]), 32'd0);
    chk("rstmid_lvl", 32'(level[3]), 32'd0);
    reset = 1'b0;
    clear_cnt();
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (rise[3] && lat < 0) lat = k;
    end
    chk("rstmid_lat", 32'(lat), 32'd6);
    chk("rstmid_rise", 32'(rise_cnt[3]), 32'd1);

    // inputs held high through reset
    in = 4'hF;
    apply_reset();
    clear_cnt();
    settle(3);
    chk("hold_rst_any", 32'(any_cnt), 32'd0);
    reset = 1'b0;
    clear_cnt();
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (level == 4'hF && lat < 0) lat = k;
    end
    chk("hold_lat", 32'(lat), 32'd6);
    chk("hold_rise", 32'(first_rise), 32'hF);
    chk("hold_any", 32'(any_cnt), 32'd1);

    // randomized traffic with occasional async resets
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          in[c]   = 1'($urandom);
          hold[c] = $urandom_range(1, 8);
        end
        hold[c]--;
      end
      if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 400) == 0) begin
        apply_reset();
        settle($urandom_range(1, 3));
        reset = 1'b0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/edge_conditioner.md
Name: edge_conditioner

Overview:
- Multi-channel, parametrised successor to the single-bit rising-edge detector.
- Each channel synchronises an asynchronous input (button or paddle switch), debounces it with a stability counter, then produces one-cycle rise, fall and mode-selected pulse outputs.
- Sits between board I/O and the Pong game FSM/paddle logic.
- Replaces ad-hoc per-button edge detectors.

Parameters:
- CH, 4: number of independent channels.
- SYNC_STAGES, 2: synchroniser flop depth, min 2.
- DB_COUNT, 4: consecutive cycles a synchronised level must differ from the debounced level before it is accepted, min 1.

Ports:
- clk  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in  input  CH  raw asynchronous channel inputs.
- mode  input  2*CH  per channel, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- level  output  CH  debounced level per channel.
- rise  output  CH  one-cycle pulse on debounced 0->1 (independent of mode).
- fall  output  CH  one-cycle pulse on debounced 1->0 (independent of mode).
- pulse  output  CH  rise/fall filtered by that channel's mode.
- any_pulse  output  1  OR-reduction of pulse.

Behaviour:
- Reset (async, active-high): sync chains, debounce counters, level, and delayed level (lvl_d) all go to 0. While reset is high and after release, rise, fall, pulse and any_pulse are 0 until a debounced transition occurs.
- Synchroniser: per channel, SYNC_STAGES flops in series. s = last stage output.
- Debounce, per channel, counter width $clog2(DB_COUNT+1):
  - If s == level: cnt <= 0.
  - Else if cnt == DB_COUNT-1: level <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
- Edge detect: lvl_d <= level every cycle.
  - rise = level & ~lvl_d; fall = ~level & lvl_d (combinational from registers).
  - pulse[i] = (mode[2i] & rise[i]) | (mode[2i+1] & fall[i]).
- Latency: input stable from before edge 1. level changes at edge SYNC_STAGES+DB_COUNT. rise/fall are high for exactly the one following cycle.
- Glitch rejection: any excursion of s lasting fewer than DB_COUNT cycles returns cnt to 0 and leaves level unchanged.
- DB_COUNT=1: level follows s with one cycle of delay, with no filtering.
- Channels are fully independent. Simultaneous events on several channels give simultaneous pulses; any_pulse is high if at least one channel pulses.
- mode is sampled combinationally. Changing mode affects only pulse, never level, rise, fall or the counters. Changing mode in the cycle a rise is high gates that rise per the new value.
- Input held high through reset: after release, level rises at edge SYNC_STAGES+DB_COUNT and one rise is produced. This is intended.
- Reset asserted mid-count: cnt and level clear immediately and no pulse is emitted. A pending transition restarts from zero after release.
- Continuous toggling faster than DB_COUNT cycles: level never changes and no pulses occur.

Test Plan (CH=4, SYNC_STAGES=2, DB_COUNT=4):
- Clean press: reset, mode=8'h55, in[0] 0->1 held. Required: level[0]=1 after edge 6; rise[0]=pulse[0]=any_pulse=1 for exactly one cycle; fall stays 0.
- Bounce rejection: in[1] toggles 1,0,1,0 with a 2-cycle period for 20 cycles, then holds 1. Required: no rise during toggling; a single rise[1] 6 edges after the final hold begins.
- Mode filtering: channel 2 press then release, run once per mode 00/01/10/11. Required pulse[2] counts over the press/release: 0, 1 (on rise), 1 (on fall), 2. rise/fall fire in all four runs.
- Simultaneous channels: in=4'b1111 in one cycle, mode=8'hFF. Required: rise=4'hF in the same single cycle; any_pulse high for one cycle.
- Reset mid-count: in[3] held high, reset asserted at edge 4 and released at edge 7. Required: no pulse during reset or before it; level[3]=1 and rise[3] occur 6 edges after release.
- Held through reset: in=4'hF during reset. Required: outputs all 0 during reset; one rise=4'hF 6 edges after release, then no further pulses.
